// File: rtl/alu_ex_stage_if.sv
// EX-stage ALU handshake bundle: operand/control input side and EX/MEM output slot.
// The ovf signal exists only when ALU_OVF_EN is defined.
interface alu_ex_stage_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             branch_taken;
   logic             illegal_op;
`ifdef ALU_OVF_EN
   logic             ovf;
`endif

   modport master (
`ifdef ALU_OVF_EN
      input  ovf,
`endif
      output flush, in_valid, alu_ctrl, a, b, out_ready,
      input  in_ready, out_valid, result, zero, branch_taken, illegal_op
   );

   modport slave (
`ifdef ALU_OVF_EN
      output ovf,
`endif
      input  flush, in_valid, alu_ctrl, a, b, out_ready,
      output in_ready, out_valid, result, zero, branch_taken, illegal_op
   );
endinterface

// File: rtl/alu_ex_stage.sv
// EX-stage ALU with a single registered EX/MEM output slot (valid/ready, flush).
// Optional signed-overflow flag enabled by defining ALU_OVF_EN.
module alu_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_ex_stage_if.slave bus
);
   typedef enum logic {EMPTY, FULL} state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_BEQ  = 4'b0110;
   localparam logic [3:0] OP_BNE  = 4'b0111;
   localparam logic [3:0] OP_BGEZ = 4'b1111;

   state_t           r_state;
   state_t           w_nextState;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_result;
   logic             w_taken;
   logic             w_illegal;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_taken;
   logic             r_illegal;
`ifdef ALU_OVF_EN
   logic             w_ovf;
   logic             r_ovf;
`endif

   assign bus.in_ready  = (r_state == EMPTY) | bus.out_ready;
   assign bus.out_valid = (r_state == FULL);
   assign w_accept      = bus.in_valid & bus.in_ready & ~bus.flush;
   assign w_sum         = bus.a + bus.b;
   assign w_diff        = bus.a - bus.b;

   always_comb begin
      w_result  = '0;
      w_taken   = 1'b0;
      w_illegal = 1'b0;
`ifdef ALU_OVF_EN
      w_ovf     = 1'b0;
`endif
      case (bus.alu_ctrl)
         OP_ADD: begin
            w_result = w_sum;
`ifdef ALU_OVF_EN
            w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            w_result = w_diff;
`ifdef ALU_OVF_EN
            w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
`endif
         end
         OP_AND:  w_result = bus.a & bus.b;
         OP_NOR:  w_result = ~(bus.a | bus.b);
         OP_OR:   w_result = bus.a | bus.b;
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_BEQ: begin
            w_result = w_diff;
            w_taken  = (bus.a == bus.b);
         end
         OP_BNE: begin
            w_result = w_diff;
            w_taken  = (bus.a != bus.b);
         end
         OP_BGEZ: begin
            w_result = bus.a;
            w_taken  = ~bus.a[WIDTH-1];
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Flush outranks both a new accept and a downstream drain.
   always_comb begin
      w_nextState = r_state;
      if (bus.flush) begin
         w_nextState = EMPTY;
      end else if (w_accept) begin
         w_nextState = FULL;
      end else if ((r_state == FULL) && bus.out_ready) begin
         w_nextState = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Slot data changes only on accept, so it holds while stalled or empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
`ifdef ALU_OVF_EN
         r_ovf     <= 1'b0;
`endif
      end else if (w_accept) begin
         r_result  <= w_result;
         r_zero    <= (w_result == '0);
         r_taken   <= w_taken;
         r_illegal <= w_illegal;
`ifdef ALU_OVF_EN
         r_ovf     <= w_ovf;
`endif
      end
   end

   assign bus.result       = r_result;
   assign bus.zero         = r_zero;
   assign bus.branch_taken = r_taken;
   assign bus.illegal_op   = r_illegal;
`ifdef ALU_OVF_EN
   assign bus.ovf          = r_ovf;
`endif
endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: directed ops push expectations, a monitor pops on each transfer.
// Overflow expectations are compared only when ALU_OVF_EN is defined.
module tb_alu_ex_stage;
   typedef struct {
      string       name;
      logic [31:0] res;
      logic        z;
      logic        t;
      logic        ill;
      logic        ov;
   } exp_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   exp_t expQ[$];

   alu_ex_stage_if #(.WIDTH(32)) bus ();

   alu_ex_stage #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one op starting just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input string name, input logic [3:0] ctrl,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic z, input logic t,
                                input logic ill, input logic ov);
      exp_t e;
      int   n;
      bus.in_valid = 1'b1;
      bus.alu_ctrl = ctrl;
      bus.a        = a;
      bus.b        = b;
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checkOutput({name, " in_ready timeout"}, 32'(bus.in_ready), 32'd1);
      end else if (!bus.flush) begin
         e.name = name;
         e.res  = res;
         e.z    = z;
         e.t    = t;
         e.ill  = ill;
         e.ov   = ov;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drainQueue();
      int n;
      n = 0;
      while ((expQ.size() != 0 || bus.out_valid) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every transfer to MEM must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput({e.name, " result"}, bus.result, e.res);
               checkOutput({e.name, " zero"}, 32'(bus.zero), 32'(e.z));
               checkOutput({e.name, " taken"}, 32'(bus.branch_taken), 32'(e.t));
               checkOutput({e.name, " illegal"}, 32'(bus.illegal_op), 32'(e.ill));
`ifdef ALU_OVF_EN
               checkOutput({e.name, " ovf"}, 32'(bus.ovf), 32'(e.ov));
`endif
            end
         end
      end
   end

   task automatic checkCleared(input string name);
      checkOutput({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({name, " result"}, bus.result, 32'd0);
      checkOutput({name, " zero"}, 32'(bus.zero), 32'd0);
      checkOutput({name, " taken"}, 32'(bus.branch_taken), 32'd0);
      checkOutput({name, " illegal"}, 32'(bus.illegal_op), 32'd0);
`ifdef ALU_OVF_EN
      checkOutput({name, " ovf"}, 32'(bus.ovf), 32'd0);
`endif
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = 4'b0000;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkCleared("reset");
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back stream with out_ready held high.
      applyStimulus("ADD 5+7",      4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("AND",          4'b0010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("NOR 0,0",      4'b0011, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("NOR to zero",  4'b0011, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("OR",           4'b0100, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("SLT -1<1",     4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("SLT 1<-1",     4'b0101, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("BEQ 9,9",      4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus("BEQ 9,8",      4'b0110, 32'd9,          32'd8,          32'd1,          1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("BNE 3,4",      4'b0111, 32'd3,          32'd4,          32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("BNE 4,4",      4'b0111, 32'd4,          32'd4,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("BGEZ neg",     4'b1111, 32'h8000_0000,  32'd5,          32'h8000_0000,  1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("BGEZ pos",     4'b1111, 32'd3,          32'd5,          32'd3,          1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("illegal 1001", 4'b1001, 32'd5,          32'd7,          32'd0,          1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus("illegal 1000", 4'b1000, 32'd1,          32'd2,          32'd0,          1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus("ADD max+1",    4'b0000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("SUB min-1",    4'b0001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("ADD 1+1",      4'b0000, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("ADD wrap",     4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("SUB 3-10",     4'b0001, 32'd3,          32'd10,         32'hFFFF_FFF9,  1'b0, 1'b0, 1'b0, 1'b0);
      drainQueue();

      // Backpressure: SUB held three cycles while a competing op is offered.
      bus.out_ready = 1'b0;
      applyStimulus("SUB 10-3",     4'b0001, 32'd10,         32'd3,          32'd7,          1'b0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'b0000;
      bus.a        = 32'd100;
      bus.b        = 32'd200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold result", bus.result, 32'd7);
         checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      applyStimulus("ADD 100+200",  4'b0000, 32'd100,        32'd200,        32'd300,        1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("no bubble out_valid", 32'(bus.out_valid), 32'd1);
      drainQueue();

      // Flush with a held slot and a concurrent incoming op: both vanish.
      bus.out_ready = 1'b0;
      applyStimulus("ADD flushed",  4'b0000, 32'd1,          32'd2,          32'd3,          1'b0, 1'b0, 1'b0, 1'b0);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'b0010;
      bus.a        = 32'hFFFF_FFFF;
      bus.b        = 32'h1234_5678;
      @(negedge clk);
      checkOutput("pre-flush out_valid", 32'(bus.out_valid), 32'd1);
      expQ.delete();
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("flush in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a held slot.
      bus.out_ready = 1'b0;
      applyStimulus("OR reset",     4'b0100, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkCleared("mid reset");
      expQ.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset release in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset release out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("ADD after reset", 4'b0000, 32'd20,      32'd22,         32'd42,         1'b0, 1'b0, 1'b0, 1'b0);
      drainQueue();

      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
